// File: rtl/regfile_pkg.sv
// Shared types and defaults for the multiport register file.
// Clear-engine state encoding and default geometry.
package regfile_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    DONE
  } clrState_t;

  localparam int DEF_DATA_W   = 64;
  localparam int DEF_ADDR_W   = 5;
  localparam int DEF_RD_PORTS = 2;
  localparam int DEF_ZERO_REG = 1;

endpackage

// File: rtl/regfile_read_port.sv
// One read port: stored value with write-to-read bypass.
// wr1 outranks wr0; a hardwired zero register outranks both.
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int ZERO_REG = DEF_ZERO_REG
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic              bypassEn,
  input  logic              wr0En,
  input  logic [ADDR_W-1:0] wr0Addr,
  input  logic [DATA_W-1:0] wr0Data,
  input  logic              wr1En,
  input  logic [ADDR_W-1:0] wr1Addr,
  input  logic [DATA_W-1:0] wr1Data,
  input  logic [DATA_W-1:0] regs [2**ADDR_W],
  output logic [DATA_W-1:0] data
);

  localparam bit HAS_ZERO = (ZERO_REG != 0);

  logic hit0;
  logic hit1;
  logic isZero;

  assign hit0   = bypassEn && wr0En && (wr0Addr == addr);
  assign hit1   = bypassEn && wr1En && (wr1Addr == addr);
  assign isZero = HAS_ZERO && (addr == '0);

  always_comb begin
    data = regs[addr];
    if (isZero) begin
      data = '0;
    end else if (hit1) begin
      data = wr1Data;
    end else if (hit0) begin
      data = wr0Data;
    end
  end

endmodule

// File: rtl/regfile_multiport.sv
// Multiport register file: two write ports, bypassed reads,
// pending-write scoreboard and a sequenced bulk-clear engine.
module regfile_multiport
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int RD_PORTS = DEF_RD_PORTS,
  parameter int ZERO_REG = DEF_ZERO_REG
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         wr0_en,
  input  logic [ADDR_W-1:0]            wr0_addr,
  input  logic [DATA_W-1:0]            wr0_data,
  input  logic                         wr1_en,
  input  logic [ADDR_W-1:0]            wr1_addr,
  input  logic [DATA_W-1:0]            wr1_data,
  input  logic [RD_PORTS*ADDR_W-1:0]   rd_addr,
  output logic [RD_PORTS*DATA_W-1:0]   rd_data,
  output logic [RD_PORTS-1:0]          rd_pending,
  input  logic                         sb_set,
  input  logic [ADDR_W-1:0]            sb_set_addr,
  input  logic                         clr_start,
  output logic                         clr_busy,
  output logic                         clr_done
);

  localparam int DEPTH = 2**ADDR_W;
  localparam bit HAS_ZERO = (ZERO_REG != 0);
  localparam logic [ADDR_W-1:0] LAST_IDX = '1;

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  sb;
  clrState_t         state;
  clrState_t         stateNext;
  logic [ADDR_W-1:0] index;

  logic idle;
  logic clearing;
  logic lastIdx;
  logic wr0Ok;
  logic wr1Ok;
  logic sbOk;

  assign idle     = (state == IDLE);
  assign clearing = (state == CLEAR);
  assign lastIdx  = (index == LAST_IDX);

  assign wr0Ok = wr0_en && !(HAS_ZERO && wr0_addr == '0);
  assign wr1Ok = wr1_en && !(HAS_ZERO && wr1_addr == '0);
  assign sbOk  = sb_set && !(HAS_ZERO && sb_set_addr == '0);

  assign clr_busy = clearing;
  assign clr_done = (state == DONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE:    if (clr_start) stateNext = CLEAR;
      CLEAR:   if (lastIdx) stateNext = DONE;
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // index parks at the terminal value instead of wrapping
  always_ff @(posedge clk) begin
    if (reset) begin
      index <= '0;
    end else if (idle && clr_start) begin
      index <= '0;
    end else if (clearing && !lastIdx) begin
      index <= index + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (clearing) begin
      regs[index] <= '0;
    end else if (idle) begin
      if (wr0Ok) regs[wr0_addr] <= wr0_data;
      if (wr1Ok) regs[wr1_addr] <= wr1_data;
    end
  end

  // set is applied last so it wins over a same-cycle clear
  always_ff @(posedge clk) begin
    if (reset) begin
      sb <= '0;
    end else if (clearing) begin
      sb[index] <= 1'b0;
    end else if (idle) begin
      if (wr0_en) sb[wr0_addr] <= 1'b0;
      if (wr1_en) sb[wr1_addr] <= 1'b0;
      if (sbOk) sb[sb_set_addr] <= 1'b1;
    end
  end

  for (genvar p = 0; p < RD_PORTS; p++) begin : g_rd
    logic [ADDR_W-1:0] a;
    assign a = rd_addr[p*ADDR_W +: ADDR_W];

    regfile_read_port #(
      .DATA_W  (DATA_W),
      .ADDR_W  (ADDR_W),
      .ZERO_REG(ZERO_REG)
    ) u_rd (
      .addr    (a),
      .bypassEn(idle),
      .wr0En   (wr0_en),
      .wr0Addr (wr0_addr),
      .wr0Data (wr0_data),
      .wr1En   (wr1_en),
      .wr1Addr (wr1_addr),
      .wr1Data (wr1_data),
      .regs    (regs),
      .data    (rd_data[p*DATA_W +: DATA_W])
    );

    assign rd_pending[p] = sb[a] && !(HAS_ZERO && a == '0);
  end

endmodule

// File: tb/tb_regfile_multiport.sv
// Randomised self-checking bench for regfile_multiport.
// Reference model: plain arrays plus a clear-position counter.
module tb_regfile_multiport;

  localparam int DW = 64;
  localparam int AW = 5;
  localparam int NP = 2;
  localparam int DEPTH = 32;

  logic clk = 1'b0;
  logic reset;
  logic wr0_en, wr1_en;
  logic [AW-1:0] wr0_addr, wr1_addr;
  logic [DW-1:0] wr0_data, wr1_data;
  logic [NP*AW-1:0] rd_addr;
  logic [NP*DW-1:0] rd_data;
  logic [NP-1:0] rd_pending;
  logic sb_set;
  logic [AW-1:0] sb_set_addr;
  logic clr_start;
  logic clr_busy, clr_done;

  regfile_multiport #(
    .DATA_W(DW), .ADDR_W(AW), .RD_PORTS(NP), .ZERO_REG(1)
  ) dut (
    .clk(clk), .reset(reset),
    .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
    .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_pending(rd_pending),
    .sb_set(sb_set), .sb_set_addr(sb_set_addr),
    .clr_start(clr_start), .clr_busy(clr_busy), .clr_done(clr_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] mem [DEPTH];
  bit pend [DEPTH];
  // -1 idle, 0..DEPTH-1 register being cleared, DEPTH = done cycle
  int clrPos = -1;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] expRead(input logic [AW-1:0] a);
    if (a == 0) return '0;
    if (clrPos < 0 && wr1_en && wr1_addr == a) return wr1_data;
    if (clrPos < 0 && wr0_en && wr0_addr == a) return wr0_data;
    return mem[a];
  endfunction

  task automatic checkOutputs();
    for (int p = 0; p < NP; p++) begin
      logic [AW-1:0] a;
      a = rd_addr[p*AW +: AW];
      chk($sformatf("rd%0d_r%0d", p, a), rd_data[p*DW +: DW], expRead(a));
      chk($sformatf("pend%0d_r%0d", p, a), 64'(rd_pending[p]), 64'(pend[a]));
    end
    chk("busy", 64'(clr_busy), 64'(clrPos >= 0 && clrPos < DEPTH));
    chk("done", 64'(clr_done), 64'(clrPos == DEPTH));
  endtask

  task automatic modelEdge();
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] = '0;
        pend[i] = 1'b0;
      end
      clrPos = -1;
    end else if (clrPos < 0) begin
      if (wr0_en && wr0_addr != 0) mem[wr0_addr] = wr0_data;
      if (wr1_en && wr1_addr != 0) mem[wr1_addr] = wr1_data;
      if (wr0_en) pend[wr0_addr] = 1'b0;
      if (wr1_en) pend[wr1_addr] = 1'b0;
      if (sb_set && sb_set_addr != 0) pend[sb_set_addr] = 1'b1;
      if (clr_start) clrPos = 0;
    end else if (clrPos < DEPTH) begin
      mem[clrPos] = '0;
      pend[clrPos] = 1'b0;
      clrPos++;
    end else begin
      clrPos = -1;
    end
  endtask

  task automatic step();
    @(negedge clk);
    checkOutputs();
    @(posedge clk);
    modelEdge();
    #1;
  endtask

  task automatic idleIn();
    reset = 1'b0;
    wr0_en = 1'b0; wr0_addr = '0; wr0_data = '0;
    wr1_en = 1'b0; wr1_addr = '0; wr1_data = '0;
    sb_set = 1'b0; sb_set_addr = '0;
    clr_start = 1'b0;
  endtask

  task automatic setRd(input int p, input logic [AW-1:0] a);
    rd_addr[p*AW +: AW] = a;
  endtask

  task automatic randIn(input int clrOdds, input int rstOdds);
    wr0_en = 1'($urandom_range(0, 1));
    wr0_addr = AW'($urandom);
    wr0_data = {$urandom, $urandom};
    wr1_en = 1'($urandom_range(0, 1));
    wr1_addr = ($urandom_range(0, 3) == 0) ? wr0_addr : AW'($urandom);
    wr1_data = {$urandom, $urandom};
    sb_set = 1'($urandom_range(0, 1));
    sb_set_addr = ($urandom_range(0, 3) == 0) ? wr0_addr : AW'($urandom);
    clr_start = ($urandom_range(1, clrOdds) == 1);
    reset = ($urandom_range(1, rstOdds) == 1);
    for (int p = 0; p < NP; p++) begin
      setRd(p, ($urandom_range(0, 2) == 0) ? wr1_addr : AW'($urandom));
    end
  endtask

  task automatic fillRegs();
    for (int i = 1; i < DEPTH; i++) begin
      idleIn();
      wr0_en = 1'b1;
      wr0_addr = AW'(i);
      wr0_data = 64'h0101_0101_0000_0000 * i + 64'(i);
      step();
    end
    idleIn();
  endtask

  task automatic readAllZero(input string tag);
    for (int i = 0; i < DEPTH; i += NP) begin
      for (int p = 0; p < NP; p++) setRd(p, AW'(i + p));
      #1;
      for (int p = 0; p < NP; p++) begin
        chk($sformatf("%s_r%0d", tag, i + p), rd_data[p*DW +: DW], 64'h0);
      end
    end
  endtask

  initial begin
    int busyCnt;
    int cyc;
    bit sawDone;

    idleIn();
    rd_addr = '0;
    reset = 1'b1;
    step();
    step();
    idleIn();

    setRd(0, 5); setRd(1, 31);
    #1;
    chk("rst_r5", rd_data[0 +: DW], 64'h0);
    chk("rst_r31", rd_data[DW +: DW], 64'h0);
    chk("rst_busy", 64'(clr_busy), 64'h0);
    chk("rst_done", 64'(clr_done), 64'h0);

    wr0_en = 1'b1; wr0_addr = 5; wr0_data = 64'hDEAD_BEEF;
    #1;
    chk("byp_r5", rd_data[0 +: DW], 64'hDEAD_BEEF);
    step();
    idleIn();
    #1;
    chk("store_r5", rd_data[0 +: DW], 64'hDEAD_BEEF);

    setRd(0, 7);
    wr0_en = 1'b1; wr0_addr = 7; wr0_data = 64'h11;
    wr1_en = 1'b1; wr1_addr = 7; wr1_data = 64'h22;
    #1;
    chk("byp_r7", rd_data[0 +: DW], 64'h22);
    step();
    idleIn();
    #1;
    chk("store_r7", rd_data[0 +: DW], 64'h22);

    setRd(0, 0); setRd(1, 0);
    wr0_en = 1'b1; wr0_addr = 0; wr0_data = 64'hFFFF;
    wr1_en = 1'b1; wr1_addr = 0; wr1_data = 64'hFFFF;
    sb_set = 1'b1; sb_set_addr = 0;
    #1;
    chk("zero_byp0", rd_data[0 +: DW], 64'h0);
    chk("zero_byp1", rd_data[DW +: DW], 64'h0);
    step();
    idleIn();
    #1;
    chk("zero_st", rd_data[DW +: DW], 64'h0);
    chk("zero_pend", 64'(rd_pending[0]), 64'h0);

    setRd(1, 3);
    sb_set = 1'b1; sb_set_addr = 3;
    #1;
    chk("sb_nobyp", 64'(rd_pending[1]), 64'h0);
    step();
    idleIn();
    #1;
    chk("sb_set", 64'(rd_pending[1]), 64'h1);
    wr1_en = 1'b1; wr1_addr = 3; wr1_data = 64'h33;
    step();
    idleIn();
    #1;
    chk("sb_clr", 64'(rd_pending[1]), 64'h0);
    sb_set = 1'b1; sb_set_addr = 3;
    wr0_en = 1'b1; wr0_addr = 3; wr0_data = 64'h44;
    step();
    idleIn();
    #1;
    chk("sb_setwins", 64'(rd_pending[1]), 64'h1);

    fillRegs();
    clr_start = 1'b1;
    step();
    busyCnt = 0;
    sawDone = 1'b0;
    cyc = 0;
    while (cyc < 100) begin
      if (clr_done) begin
        sawDone = 1'b1;
        break;
      end
      if (clr_busy) busyCnt++;
      randIn(4, 1000000);
      reset = 1'b0;
      step();
      cyc++;
    end
    chk("clr_busy_cycles", 64'(busyCnt), 64'd32);
    chk("clr_done_seen", 64'(sawDone), 64'h1);
    idleIn();
    step();
    readAllZero("clr");
    chk("clr_idle_busy", 64'(clr_busy), 64'h0);

    fillRegs();
    clr_start = 1'b1;
    step();
    idleIn();
    for (int i = 0; i < 10; i++) step();
    reset = 1'b1;
    step();
    idleIn();
    #1;
    chk("rstmid_busy", 64'(clr_busy), 64'h0);
    chk("rstmid_done", 64'(clr_done), 64'h0);
    readAllZero("rstmid");
    for (int i = 0; i < 3; i++) step();

    for (int i = 0; i < 800; i++) begin
      randIn(60, 150);
      step();
    end
    idleIn();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
